// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC, ROM fetch handshake, fetch/execute phase and C/Z flags for the 4-bit CPU
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   en                    run enable; low holds in FETCH without requesting
//   rom_req/rom_addr      ROM read request and address (the PC)
//   rom_valid/rom_data    ROM response; rom_data = {opcode, operand}
//   i, operand            registered instruction fields
//   phase                 0 = fetch, 1 = execute
//   inc_pc, load_pc,
//   pc_load_val           decoder PC controls (load beats increment)
//   load_flag, alu_c,
//   alu_z                 decoder flag capture from the ALU
//   C, Z                  registered carry and zero flags
module fetch_sequencer #(
   parameter int              PC_W   = 12,
   parameter logic [PC_W-1:0] RST_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   output logic            rom_req,
   output logic [PC_W-1:0] rom_addr,
   input  logic            rom_valid,
   input  logic [7:0]      rom_data,
   output logic [3:0]      i,
   output logic [3:0]      operand,
   output logic            phase,
   input  logic            inc_pc,
   input  logic            load_pc,
   input  logic [PC_W-1:0] pc_load_val,
   input  logic            load_flag,
   input  logic            alu_c,
   input  logic            alu_z,
   output logic            C,
   output logic            Z
);
   typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_t;
   state_t          state;
   logic [PC_W-1:0] pc;
   assign phase    = state;
   assign rom_addr = pc;
   // rst_n gates the request so it reads 0 while reset is held, even with en high
   assign rom_req  = rst_n && en && state == FETCH;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= FETCH;
         pc      <= RST_PC;
         i       <= '0;
         operand <= '0;
         C       <= 1'b0;
         Z       <= 1'b0;
      end else if (state == FETCH) begin
         if (en && rom_valid) begin
            {i, operand} <= rom_data;
            state        <= EXEC;
            pc           <= inc_pc ? pc + 1'b1 : pc;
         end
      end else begin
         pc    <= load_pc ? pc_load_val : inc_pc ? pc + 1'b1 : pc;
         C     <= load_flag ? alu_c : C;
         Z     <= load_flag ? alu_z : Z;
         state <= FETCH;
      end
   end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;
   localparam int PC_W = 12;
   logic clk = 0, rst_n = 0, en = 0, rom_valid = 0, inc_pc = 0, load_pc = 0, load_flag = 0, alu_c = 0, alu_z = 0;
   logic [7:0]      rom_data = '0;
   logic [PC_W-1:0] pc_load_val = '0;
   logic            rom_req, phase, C, Z;
   logic [PC_W-1:0] rom_addr;
   logic [3:0]      i, operand;
   int n_chk = 0, n_fail = 0;
   logic [PC_W-1:0] mpc = '0;
   logic            mc = 0, mz = 0;
   logic [7:0]      mir = '0;
   logic [7:0]      sb[$];

   fetch_sequencer #(.PC_W(PC_W), .RST_PC('0)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .rom_req(rom_req), .rom_addr(rom_addr),
      .rom_valid(rom_valid), .rom_data(rom_data), .i(i), .operand(operand), .phase(phase),
      .inc_pc(inc_pc), .load_pc(load_pc), .pc_load_val(pc_load_val), .load_flag(load_flag),
      .alu_c(alu_c), .alu_z(alu_z), .C(C), .Z(Z)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_fetch(input logic req_exp);
      chk("phase_f", 32'(phase), 32'(1'b0));
      chk("req_f", 32'(rom_req), 32'(req_exp));
      chk("addr_f", 32'(rom_addr), 32'(mpc));
      chk("ir_hold", 32'({i, operand}), 32'(mir));
      chk("c_f", 32'(C), 32'(mc));
      chk("z_f", 32'(Z), 32'(mz));
   endtask

   // Decoder controls are driven noisy during FETCH: only inc_pc on the valid edge may act.
   task automatic noisy_ctrl();
      load_pc = 1; load_flag = 1; alu_c = ~mc; alu_z = ~mz; pc_load_val = PC_W'($urandom);
   endtask

   task automatic fetch(input logic [7:0] d, input int waits, input logic inc);
      repeat (waits) begin
         @(negedge clk);
         check_fetch(en);
         en = 1; rom_valid = 0; inc_pc = 1; noisy_ctrl();
      end
      @(negedge clk);
      check_fetch(en);
      en = 1; rom_valid = 1; rom_data = d; inc_pc = inc; noisy_ctrl();
      sb.push_back(d);
      if (inc) mpc = PC_W'(mpc + 1);
   endtask

   task automatic exec(input logic lp, input logic ip, input logic [PC_W-1:0] val,
                       input logic lf, input logic c, input logic z, input logic en_v);
      @(negedge clk);
      chk("phase_e", 32'(phase), 32'(1'b1));
      chk("req_e", 32'(rom_req), 32'(1'b0));
      chk("addr_e", 32'(rom_addr), 32'(mpc));
      chk("sb_ready", 32'(sb.size() != 0), 32'(1'b1));
      if (sb.size() != 0) mir = sb.pop_front();
      chk("ir_exec", 32'({i, operand}), 32'(mir));
      rom_valid = 0; en = en_v; load_pc = lp; inc_pc = ip; pc_load_val = val;
      load_flag = lf; alu_c = c; alu_z = z;
      mpc = lp ? val : ip ? PC_W'(mpc + 1) : mpc;
      if (lf) begin mc = c; mz = z; end
   endtask

   task automatic stall(input int n);
      repeat (n) begin
         @(negedge clk);
         check_fetch(en);
         en = 0; rom_valid = 1; rom_data = 8'hEE; inc_pc = 1; noisy_ctrl();
      end
   endtask

   initial begin
      en = 1;
      repeat (2) @(negedge clk);
      check_fetch(1'b0);
      rst_n = 1;
      // basic fetch, back-to-back valid
      fetch(8'hC5, 0, 1);
      exec(0, 0, '0, 0, 0, 0, 1);
      // ROM wait states, then load_pc beats inc_pc and flags captured
      fetch(8'h3E, 3, 0);
      exec(1, 1, 12'h3A7, 1, 1, 0, 1);
      fetch(8'h71, 0, 0);
      exec(1, 0, 12'hFFF, 0, 0, 1, 1);
      // PC wraps 0xFFF -> 0x000
      fetch(8'h9A, 1, 1);
      exec(0, 1, '0, 0, 1, 1, 1);
      // en dropped during EXEC: it completes, then stalls in FETCH
      fetch(8'h42, 0, 0);
      exec(0, 1, '0, 1, 0, 1, 0);
      stall(5);
      fetch(8'h5D, 2, 1);
      exec(0, 0, '0, 1, 1, 1, 1);
      // asynchronous reset mid-EXEC discards pending PC/flag updates
      fetch(8'hB6, 0, 1);
      exec(1, 1, 12'h123, 1, 0, 0, 1);
      #2 rst_n = 0;
      mpc = '0; mc = 0; mz = 0; mir = '0;
      #1;
      chk("rst_phase", 32'(phase), 32'(1'b0));
      chk("rst_req", 32'(rom_req), 32'(1'b0));
      chk("rst_addr", 32'(rom_addr), 32'(mpc));
      chk("rst_ir", 32'({i, operand}), 32'(mir));
      chk("rst_c", 32'(C), 32'(mc));
      chk("rst_z", 32'(Z), 32'(mz));
      @(negedge clk);
      rst_n = 1; rom_valid = 0; load_pc = 0; inc_pc = 0; load_flag = 0;
      fetch(8'h11, 0, 1);
      exec(0, 1, '0, 1, 1, 0, 1);
      @(negedge clk);
      check_fetch(1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction fetch and phase sequencer for the 4-bit CPU, directly upstream of the microcode decoder.
- Holds the 12-bit PC and fetches 8-bit instruction bytes from program ROM over a req/valid handshake.
- Splits each byte into opcode i[3:0] and operand[3:0] for the decoder and the operand bus.
- Generates the fetch/execute phase bit and holds the C/Z flag register that the decoder consumes.
- Applies the decoder's PC and flag controls (inc_pc, load_pc, load_flag).

Parameters:
PC_W, 12, program counter / ROM address width
RST_PC, 0, PC value after reset

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
en  in  1  run enable; low = hold in FETCH without issuing ROM requests
rom_req  out  1  ROM read request
rom_addr  out  PC_W  ROM address (= PC)
rom_valid  in  1  ROM data valid for the current request
rom_data  in  8  instruction byte, [7:4] opcode, [3:0] operand
i  out  4  registered opcode to decoder
operand  out  4  registered operand to operand bus
phase  out  1  0 = fetch, 1 = execute (to decoder)
inc_pc  in  1  decoder control: increment PC
load_pc  in  1  decoder control: load PC from pc_load_val
pc_load_val  in  PC_W  jump target
load_flag  in  1  decoder control: capture ALU flags
alu_c  in  1  ALU carry out
alu_z  in  1  ALU zero
C  out  1  registered carry flag
Z  out  1  registered zero flag

Behaviour:
- Reset (async, rst_n=0): PC=RST_PC, state=FETCH, phase=0, rom_req=0, i=0, operand=0, C=0, Z=0. Deassertion takes effect at the next clk edge.
- FETCH state:
  - phase=0.
  - rom_req = en. rom_addr = PC combinationally.
  - Request held, PC and address stable, until rom_valid=1 is sampled with rom_req=1.
  - On that edge: {i, operand} <= rom_data; state -> EXEC.
  - On that same edge, if inc_pc=1: PC <= PC+1.
  - rom_valid while rom_req=0 is ignored.
  - en=0: remain in FETCH, rom_req=0, nothing updates.
- EXEC state (exactly one cycle, regardless of en):
  - phase=1, rom_req=0. i and operand are stable for the whole cycle.
  - At the end of the cycle:
    - load_pc=1: PC <= pc_load_val.
    - else inc_pc=1: PC <= PC+1.
    - else PC holds. load_pc has priority over inc_pc.
  - load_flag=1: C <= alu_c, Z <= alu_z; otherwise C and Z hold.
  - Flag capture and PC update happen on the same edge.
  - state -> FETCH.
- Flags change only in EXEC. load_flag in FETCH is ignored. load_pc in FETCH is ignored.
- PC arithmetic is modulo 2^PC_W: 0xFFF+1 -> 0x000, no carry out.
- Latency: minimum 2 cycles per instruction (rom_valid in the first FETCH cycle); each ROM wait cycle adds 1.
- i, operand, C, Z are register outputs, never combinational from inputs.
- Reset asserted mid-fetch or mid-exec aborts the operation immediately. No partial PC or flag update.
- No illegal states: a 1-bit state encoding (phase is the state bit).

Test Plan:
1. Reset then en=1, rom_valid=1 every cycle, rom_data=0xC5, decoder inc_pc=1 in FETCH -> rom_addr 0x000, next cycle phase=1, i=0xC, operand=0x5, PC=0x001.
2. rom_valid delayed 3 cycles after rom_req -> rom_req and rom_addr stable for 4 cycles, phase stays 0, IR unchanged until the valid edge.
3. EXEC with load_pc=1, inc_pc=1, pc_load_val=0x3A7 -> PC=0x3A7 (load wins), next rom_addr=0x3A7.
4. PC=0xFFF, fetch with inc_pc=1 -> PC=0x000. EXEC with load_flag=1, alu_c=1, alu_z=0 -> C=1, Z=0; following EXEC with load_flag=0 -> flags unchanged.
5. en=0 during FETCH for 5 cycles -> rom_req=0, PC/i/phase frozen. en=0 asserted during EXEC -> EXEC still completes, then stall in FETCH.
6. rst_n pulsed low mid-EXEC, asynchronously between edges -> outputs clear immediately to the reset values; load_flag and load_pc in that cycle have no effect.
